// File: rtl/mem_access_seq_if.sv
// Bus bundle between the multicycle CPU requesters (fetch and data path),
// the single-port memory, and the mem_access_seq sequencer.
//
// Handshake: if_req / dt_req are levels that the requester raises and holds
// until it sees its one-cycle done pulse (if_done / dt_done). The matching
// grant (if_gnt / dt_gnt) is a level that stays high from the ISSUE cycle
// through the DONE cycle. A request that is still high in the cycle after
// done is taken as a new request. Dropping a request early does not cancel a
// transaction that has already been granted.
//
// The memory side is address/strobe/data only: mem_addr and mem_wdata are
// registered, mem_wr is a one-cycle strobe, and mem_rdata is expected to be
// valid READ_LAT cycles after mem_addr is presented.
//
// dbg_state mirrors the sequencer FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE).
interface mem_access_seq_if #(
  parameter int ADDR_W = 32
);
  // requester -> sequencer
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              dt_req;
  logic              dt_we;
  logic [ADDR_W-1:0] dt_addr;
  logic [31:0]       dt_wdata;
  // memory -> sequencer
  logic [31:0]       mem_rdata;
  // sequencer -> memory
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  // sequencer -> requesters
  logic              if_gnt;
  logic              dt_gnt;
  logic              if_done;
  logic              dt_done;
  logic [31:0]       rdata;
  logic              busy;
  logic [1:0]        dbg_state;

  // Requesters and the memory model sit on the master side.
  modport master (
    output if_req, if_addr, dt_req, dt_we, dt_addr, dt_wdata, mem_rdata,
    input  mem_addr, mem_wr, mem_wdata, if_gnt, dt_gnt, if_done, dt_done,
           rdata, busy, dbg_state
  );

  // The sequencer sits on the slave side.
  modport slave (
    input  if_req, if_addr, dt_req, dt_we, dt_addr, dt_wdata, mem_rdata,
    output mem_addr, mem_wr, mem_wdata, if_gnt, dt_gnt, if_done, dt_done,
           rdata, busy, dbg_state
  );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: arbiter and sequencer for the single-port instruction/data
// memory of the multicycle CPU. Grants either the fetch path or the data
// path, drives the registered memory address / write data / write strobe,
// counts out the fixed read latency, and returns a one-cycle done pulse plus
// a registered read word.
//
// FSM: IDLE -> ISSUE -> (WAIT x READ_LAT) -> DONE -> IDLE for reads,
//      IDLE -> ISSUE -> DONE -> IDLE for stores.
//
// Optional feature macro: MEM_SEQ_RR_EN
//   undefined : data path wins over fetch on simultaneous requests.
//   defined   : round-robin on simultaneous requests using a last-grant
//               register that resets to DATA (first contended grant -> fetch).
//
// READ_LAT legal range is 1..15 (the latency counter is 4 bits wide).
module mem_access_seq #(
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  mem_access_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter load value: WAIT runs READ_LAT cycles, the last of which has
  // the counter at zero and captures mem_rdata.
  localparam logic [3:0] CNT_LOAD = 4'(READ_LAT - 1);

  state_t            state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q,     rdata_d;
  logic              we_q,        we_d;
  logic              mem_wr_q,    mem_wr_d;
  logic              if_gnt_q,    if_gnt_d;
  logic              dt_gnt_q,    dt_gnt_d;
  logic              if_done_q,   if_done_d;
  logic              dt_done_q,   dt_done_d;
  logic              busy_q,      busy_d;

  logic              pick_dt;
  logic              pick_if;

`ifdef MEM_SEQ_RR_EN
  // 1 = data path was granted last, 0 = fetch was granted last.
  logic last_dt_q, last_dt_d;

  // Round-robin pick: on contention, favour whoever was not granted last.
  always_comb begin
    pick_dt   = bus.dt_req && !(bus.if_req && last_dt_q);
    last_dt_d = last_dt_q;
    if (state_q == ST_IDLE && (bus.dt_req || bus.if_req)) begin
      last_dt_d = pick_dt;
    end
  end
`else
  // Fixed priority pick: the data path always wins on contention.
  always_comb begin
    pick_dt = bus.dt_req;
  end
`endif

  assign pick_if = bus.if_req && !pick_dt;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    we_d        = we_q;
    mem_wr_d    = 1'b0;
    if_gnt_d    = if_gnt_q;
    dt_gnt_d    = dt_gnt_q;
    if_done_d   = 1'b0;
    dt_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_dt) begin
          mem_addr_d  = bus.dt_addr;
          mem_wdata_d = bus.dt_wdata;
          we_d        = bus.dt_we;
          mem_wr_d    = bus.dt_we;
          dt_gnt_d    = 1'b1;
          state_d     = ST_ISSUE;
        end else if (pick_if) begin
          // Fetch is always a read; write data is left as it was.
          mem_addr_d  = bus.if_addr;
          we_d        = 1'b0;
          if_gnt_d    = 1'b1;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          // Store completes as soon as the strobe has been presented.
          if_done_d = if_gnt_q;
          dt_done_d = dt_gnt_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d   = bus.mem_rdata;
          if_done_d = if_gnt_q;
          dt_done_d = dt_gnt_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        if_gnt_d = 1'b0;
        dt_gnt_d = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        if_gnt_d = 1'b0;
        dt_gnt_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      we_q        <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      dt_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dt_done_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_SEQ_RR_EN
      last_dt_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      mem_wr_q    <= mem_wr_d;
      if_gnt_q    <= if_gnt_d;
      dt_gnt_q    <= dt_gnt_d;
      if_done_q   <= if_done_d;
      dt_done_q   <= dt_done_d;
      busy_q      <= busy_d;
`ifdef MEM_SEQ_RR_EN
      last_dt_q   <= last_dt_d;
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.dt_gnt    = dt_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.dt_done   = dt_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (READ_LAT=2 and READ_LAT=5) share
// the stimulus variables; sel steers requests to one of them and selects
// which one is observed. A latency-pipelined memory model answers reads.
module tb_mem_access_seq;

  logic Clk;
  logic Reset;

  // Shared stimulus
  logic        sel;
  logic        if_req_v;
  logic [31:0] if_addr_v;
  logic        dt_req_v;
  logic        dt_we_v;
  logic [31:0] dt_addr_v;
  logic [31:0] dt_wdata_v;

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata[2];
  int          total;
  int          passes;
  int          fails;

  mem_access_seq_if #(.ADDR_W(32)) bus_a ();
  mem_access_seq_if #(.ADDR_W(32)) bus_b ();

  mem_access_seq #(.READ_LAT(2), .ADDR_W(32)) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_a.slave)
  );

  mem_access_seq #(.READ_LAT(5), .ADDR_W(32)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_b.slave)
  );

  // Memory contents as seen by the bench.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C22_0004;
    return {a[15:0] ^ 16'hA5C3, a[15:0]} + 32'h1357_9BDF;
  endfunction

  // Memory with a fixed read latency: data for the address presented in
  // cycle t appears on mem_rdata in cycle t+READ_LAT.
  logic [31:0] pipe_a[2];
  logic [31:0] pipe_b[5];

  always @(posedge Clk) begin
    pipe_a[0] <= mem_fn(bus_a.mem_addr);
    pipe_a[1] <= pipe_a[0];
    pipe_b[0] <= mem_fn(bus_b.mem_addr);
    for (int k = 1; k < 5; k++) pipe_b[k] <= pipe_b[k-1];
  end

  assign bus_a.mem_rdata = pipe_a[1];
  assign bus_b.mem_rdata = pipe_b[4];

  assign bus_a.if_req   = if_req_v && !sel;
  assign bus_a.if_addr  = if_addr_v;
  assign bus_a.dt_req   = dt_req_v && !sel;
  assign bus_a.dt_we    = dt_we_v;
  assign bus_a.dt_addr  = dt_addr_v;
  assign bus_a.dt_wdata = dt_wdata_v;

  assign bus_b.if_req   = if_req_v && sel;
  assign bus_b.if_addr  = if_addr_v;
  assign bus_b.dt_req   = dt_req_v && sel;
  assign bus_b.dt_we    = dt_we_v;
  assign bus_b.dt_addr  = dt_addr_v;
  assign bus_b.dt_wdata = dt_wdata_v;

  // Observed outputs of the selected instance
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic        o_wr, o_ifg, o_dtg, o_ifd, o_dtd, o_busy;
  logic [1:0]  o_state;

  assign o_addr  = sel ? bus_b.mem_addr  : bus_a.mem_addr;
  assign o_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
  assign o_rdata = sel ? bus_b.rdata     : bus_a.rdata;
  assign o_wr    = sel ? bus_b.mem_wr    : bus_a.mem_wr;
  assign o_ifg   = sel ? bus_b.if_gnt    : bus_a.if_gnt;
  assign o_dtg   = sel ? bus_b.dt_gnt    : bus_a.dt_gnt;
  assign o_ifd   = sel ? bus_b.if_done   : bus_a.if_done;
  assign o_dtd   = sel ? bus_b.dt_done   : bus_a.dt_done;
  assign o_busy  = sel ? bus_b.busy      : bus_a.busy;
  assign o_state = sel ? bus_b.dbg_state : bus_a.dbg_state;

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to the next cycle; outputs are sampled and inputs driven here.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One transaction. Cycle 0 is the cycle in which the request is raised.
  // drop_at >= 0 drops the request in that cycle; reset_at >= 0 pulses Reset
  // in that cycle and expects the held request to be re-granted afterwards.
  task automatic txn(input string tag, input bit use_b, input bit is_if, input bit we,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int drop_at, input int reset_at);
    int lat, issue_t, done_t, wr_cnt, gnt_cnt;
    bit seen, bad_gnt;
    lat     = use_b ? 5 : 2;
    sel     = use_b;
    issue_t = 1;
    done_t  = 0;
    if (is_if) begin
      if_addr_v = addr;
      if_req_v  = 1'b1;
    end else begin
      dt_addr_v  = addr;
      dt_we_v    = we;
      dt_wdata_v = wdata;
      dt_req_v   = 1'b1;
    end
    exp_q.push_back(we ? model_rdata[use_b] : mem_fn(addr));
    seen = 0; wr_cnt = 0; gnt_cnt = 0; bad_gnt = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (t == reset_at) Reset = 1'b1;
      if (t == drop_at) begin
        if_req_v = 1'b0;
        dt_req_v = 1'b0;
      end
      if (reset_at >= 0 && t == reset_at + 1) begin
        check({tag, "_rst_state"}, 32'(o_state), 32'd0);
        check({tag, "_rst_busy"},  32'(o_busy), 32'd0);
        check({tag, "_rst_addr"},  o_addr, 32'd0);
        check({tag, "_rst_done"},  32'({o_ifd, o_dtd}), 32'd0);
        check({tag, "_rst_gnt"},   32'({o_ifg, o_dtg, o_wr}), 32'd0);
        check({tag, "_rst_rdata"}, o_rdata, 32'd0);
        Reset = 1'b0;
        model_rdata[0] = 32'd0;
        model_rdata[1] = 32'd0;
        issue_t = t + 1;
        gnt_cnt = 0;
      end
      done_t = issue_t + (we ? 1 : lat + 1);
      if (o_wr) wr_cnt++;
      if (is_if ? o_dtg : o_ifg) bad_gnt = 1;
      if (t >= issue_t && (is_if ? o_ifg : o_dtg)) gnt_cnt++;
      if (t == issue_t) begin
        check({tag, "_addr"}, o_addr, addr);
        check({tag, "_gnt"},  32'(is_if ? o_ifg : o_dtg), 32'd1);
        if (we) check({tag, "_wdata"}, o_wdata, wdata);
      end
      if (o_ifd || o_dtd) begin
        seen = 1;
        check({tag, "_done_cycle"}, 32'(t), 32'(done_t));
        check({tag, "_done_who"}, 32'({o_ifd, o_dtd}), is_if ? 32'd2 : 32'd1);
        check({tag, "_rdata"}, o_rdata, exp_q.pop_front());
        model_rdata[use_b] = o_rdata;
        if_req_v = 1'b0;
        dt_req_v = 1'b0;
      end
      cyc();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) exp_q.delete();
    check({tag, "_idle_after"}, 32'({o_busy, o_ifg, o_dtg}), 32'd0);
    check({tag, "_wr_cycles"}, 32'(wr_cnt), 32'(we));
    check({tag, "_gnt_cycles"}, 32'(gnt_cnt), 32'(done_t - issue_t + 1));
    check({tag, "_other_gnt"}, 32'(bad_gnt), 32'd0);
    if (drop_at >= 0) begin
      cyc();
      check({tag, "_no_regrant"}, 32'({o_busy, o_ifg, o_dtg}), 32'd0);
    end
  endtask

  initial begin
    int          n_done;
    int          done_at[2];
    logic [1:0]  who[2];
    bit          both_gnt;
    bit          first_if;
    logic [31:0] a;

    total = 0; passes = 0; fails = 0;
    sel = 1'b0;
    if_req_v = 1'b0; if_addr_v = 32'd0;
    dt_req_v = 1'b0; dt_we_v = 1'b0; dt_addr_v = 32'd0; dt_wdata_v = 32'd0;
    model_rdata[0] = 32'd0;
    model_rdata[1] = 32'd0;

    // Reset state
    Reset = 1'b1;
    repeat (3) cyc();
    check("reset_state", 32'(o_state), 32'd0);
    check("reset_busy",  32'(o_busy), 32'd0);
    check("reset_strobes", 32'({o_wr, o_ifg, o_dtg, o_ifd, o_dtd}), 32'd0);
    check("reset_addr",  o_addr, 32'd0);
    check("reset_wdata", o_wdata, 32'd0);
    check("reset_rdata", o_rdata, 32'd0);
    Reset = 1'b0;

    // Directed transactions on the READ_LAT=2 instance
    txn("fetch10", 1'b0, 1'b1, 1'b0, 32'h10, 32'd0, -1, -1);
    txn("store40", 1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, -1, -1);
    txn("load20",  1'b0, 1'b0, 1'b0, 32'h20, 32'd0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 63)) * 4 + 32'(i) * 32'h1000;
      txn("rand_ld", 1'b0, i[0] ? 1'b1 : 1'b0, 1'b0, a, 32'd0, -1, -1);
    end
    txn("rand_st", 1'b0, 1'b0, 1'b1, 32'h300, $urandom(), -1, -1);

    // READ_LAT=5 instance
    txn("lat5_ld80", 1'b1, 1'b0, 1'b0, 32'h80, 32'd0, -1, -1);
    txn("lat5_st84", 1'b1, 1'b0, 1'b1, 32'h84, $urandom(), -1, -1);
    txn("lat5_if88", 1'b1, 1'b1, 1'b0, 32'h88, 32'd0, -1, -1);

    // Request dropped mid-read, then reset during WAIT with held request
    txn("drop",  1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 2, -1);
    txn("rstmid", 1'b0, 1'b1, 1'b0, 32'h70, 32'd0, -1, 2);

    // Contention right after reset: both requests raised together
    sel = 1'b0;
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    model_rdata[0] = 32'd0;
    model_rdata[1] = 32'd0;
    cyc();
`ifdef MEM_SEQ_RR_EN
    first_if = 1'b1;
`else
    first_if = 1'b0;
`endif
    if_addr_v = 32'h60;
    dt_addr_v = 32'h50;
    dt_we_v   = 1'b0;
    if_req_v  = 1'b1;
    dt_req_v  = 1'b1;
    exp_q.push_back(first_if ? mem_fn(32'h60) : mem_fn(32'h50));
    exp_q.push_back(first_if ? mem_fn(32'h50) : mem_fn(32'h60));
    n_done = 0; both_gnt = 0;
    done_at[0] = -1; done_at[1] = -1;
    who[0] = 2'b00; who[1] = 2'b00;
    for (int t = 0; t < 40 && n_done < 2; t++) begin
      if (o_ifg && o_dtg) both_gnt = 1;
      if (o_ifd && o_dtd) both_gnt = 1;
      if (t == 5) check("cont_idle_gap", 32'({o_busy, o_ifg, o_dtg}), 32'd0);
      if (o_ifd || o_dtd) begin
        done_at[n_done] = t;
        who[n_done] = {o_ifd, o_dtd};
        check("cont_rdata", o_rdata, exp_q.pop_front());
        if (o_ifd) if_req_v = 1'b0;
        if (o_dtd) dt_req_v = 1'b0;
        n_done++;
      end
      cyc();
    end
    check("cont_n_done", 32'(n_done), 32'd2);
    check("cont_first_cycle", 32'(done_at[0]), 32'd4);
    check("cont_second_cycle", 32'(done_at[1]), 32'd9);
    check("cont_first_who", 32'(who[0]), first_if ? 32'd2 : 32'd1);
    check("cont_second_who", 32'(who[1]), first_if ? 32'd1 : 32'd2);
    check("cont_exclusive", 32'(both_gnt), 32'd0);
    if_req_v = 1'b0;
    dt_req_v = 1'b0;
    exp_q.delete();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Sequencer and arbiter for the single-port instruction/data memory of the multicycle CPU. The fetch path (IR load) and the data path (LW/SW) each request the memory. The block grants one requester, drives the memory address, write strobe and write data, and counts out the fixed read latency. It returns a one-cycle done pulse and a registered read word, so the control unit waits on `done` instead of running hard-coded delay states.

## Interface
Parameters:
- READ_LAT, 2, memory read latency in cycles from address presented to data valid; legal range 1..15
- ADDR_W, 32, address width

Ports:
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request, level, held until if_done
- if_addr  in  ADDR_W  fetch address (PC)
- dt_req  in  1  data request, level, held until dt_done
- dt_we  in  1  data request is a store (1) or load (0)
- dt_addr  in  ADDR_W  data address (ALUOut)
- dt_wdata  in  32  store data (B register)
- mem_rdata  in  32  memory read data
- mem_addr  out  ADDR_W  memory address, registered
- mem_wr  out  1  memory write strobe
- mem_wdata  out  32  memory write data, registered
- if_gnt  out  1  fetch owns memory, level for whole transaction
- dt_gnt  out  1  data path owns memory, level for whole transaction
- if_done  out  1  one-cycle pulse, fetch transaction complete
- dt_done  out  1  one-cycle pulse, data transaction complete
- rdata  out  32  captured read word, valid from done cycle until next capture
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrates and latches the request:
  - Sample if_req/dt_req.
  - On a grant, latch address, we and wdata into mem_addr/mem_wdata and an internal we flag.
  - Set the grant bit and go to ISSUE.
  - With no request, stay in IDLE.
  - Fetch is always a read (we=0).
- ISSUE:
  - mem_wr = latched we.
  - Write: go to DONE.
  - Read: load latency counter with READ_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter.
  - At 0, capture mem_rdata into rdata and go to DONE.
- DONE:
  - Pulse the done line of the granted requester.
  - Clear the grant and go to IDLE.
- mem_addr and mem_wdata are stable from ISSUE through DONE. They hold their last value in IDLE.
- Dropping req mid-transaction does not abort it. The transaction completes and the done pulse is still issued.
- A req still high in the cycle after done is treated as a new request. There is always at least one IDLE cycle between transactions.
- Arbitration when both requests are pending: see Configuration. A lone requester is always granted.
- if_gnt and dt_gnt are never both 1. if_done and dt_done are never both 1.
- Store transactions leave rdata unchanged.

## Timing
- Reset (synchronous): state=IDLE, counter=0, mem_addr=0, mem_wdata=0, rdata=0, last-grant=DATA. All strobes, grants, done pulses and busy = 0.
- Request seen in IDLE at cycle 0:
  - ISSUE at cycle 1, with the address on mem_addr.
  - Read data is valid on mem_rdata at cycle 1+READ_LAT and is captured at the end of that cycle.
  - done=1 and rdata valid at cycle 2+READ_LAT.
- Read latency req→done = READ_LAT+2 cycles. Store latency req→done = 2 cycles.
- mem_wr is high in exactly one cycle (ISSUE) per store.
- Reset mid-transaction:
  - Returns to IDLE on the next edge.
  - No done pulse, and mem_wr is 0 from that edge.
  - The requester must reissue.
- Requests arriving while busy wait. They are evaluated in the next IDLE cycle.

## Configuration
- MEM_SEQ_RR_EN undefined:
  - Fixed priority, data over fetch, on simultaneous requests.
  - The last-grant register is absent.
- MEM_SEQ_RR_EN defined:
  - Round-robin on simultaneous requests: grant the requester not granted last.
  - The last-grant register updates on every grant and resets to DATA, so the first contended grant after reset goes to fetch.

## Test plan
- Fetch read, READ_LAT=2: if_req=1, if_addr=0x10, mem returns 0x8C220004 → mem_addr=0x10 at cycle 1, if_done pulse at cycle 4, rdata=0x8C220004, mem_wr never 1.
- Store: dt_req=1, dt_we=1, dt_addr=0x40, dt_wdata=0xDEADBEEF → mem_wr=1 only at cycle 1 with mem_addr=0x40, mem_wdata=0xDEADBEEF; dt_done at cycle 2; rdata unchanged.
- Contention, both req at cycle 0 held until done → without MEM_SEQ_RR_EN: dt first, if second, one IDLE cycle between. With MEM_SEQ_RR_EN, first contention after reset: if first, then dt.
- READ_LAT=5 load at 0x80 → dt_done at cycle 7, rdata equals mem_rdata sampled at cycle 6; gnt high cycles 1–7.
- Reset asserted during WAIT → next cycle state IDLE, busy=0, no done pulse, mem_addr=0; a held req is re-granted after Reset drops.
- Req dropped at cycle 2 of a read → transaction completes, done still pulses at cycle 2+READ_LAT, next cycle IDLE with no re-grant.
